// File: rtl/pool2d_mc_pkg.sv
// Shared constants, mode encodings and FSM state type for the multi-channel
// 2x2/stride-2 pooling engine.
package pool_pkg;

  localparam int SIZE_1           = 16;
  localparam int CH               = 4;
  localparam int SIZE_address_pix = 13;
  localparam int MAT_W            = 10;
  localparam int TAPS             = 4;

  localparam logic [1:0] POOL_MAX     = 2'b00;
  localparam logic [1:0] POOL_AVG     = 2'b01;
  localparam logic [1:0] POOL_MAXRELU = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pool_state_e;

endpackage

// File: rtl/pool2d_mc_if.sv
// Pixel-memory bus between the pooling engine (master) and the memory (slave).
interface pool2d_mc_if;
  import pool_pkg::*;

  logic [SIZE_address_pix-1:0] read_addressp;
  logic                        re;
  logic [SIZE_1*CH-1:0]        qp;
  logic [SIZE_address_pix-1:0] write_addressp;
  logic                        we;
  logic [SIZE_1*CH-1:0]        dp;

  modport master (
    output read_addressp, re, write_addressp, we, dp,
    input  qp
  );

  modport slave (
    input  read_addressp, re, write_addressp, we, dp,
    output qp
  );

endinterface

// File: rtl/pool2d_mc_lane.sv
// One channel lane: running max and running sum over the four window taps,
// final result selected combinationally while the last tap is on the bus.
module pool_lane
  import pool_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [1:0]        tap_i,
  input  logic [1:0]        mode_i,
  input  logic [SIZE_1-1:0] data_i,
  output logic [SIZE_1-1:0] res_o
);

  logic signed [SIZE_1-1:0] max_q, max_d, x;
  logic signed [SIZE_1+1:0] sum_q, sum_d, x_ext;

  always_comb begin
    x     = data_i;
    x_ext = {{2{data_i[SIZE_1-1]}}, data_i};
    max_d = x;
    sum_d = x_ext;
    if (tap_i != 2'd0) begin
      max_d = (x > max_q) ? x : max_q;
      sum_d = sum_q + x_ext;
    end
  end

  // Dropping the two LSBs of the widened sum is the floor divide by four.
  always_comb begin
    res_o = max_d;
    case (mode_i)
      POOL_AVG:     res_o = sum_d[SIZE_1+1:2];
      POOL_MAXRELU: res_o = max_d[SIZE_1-1] ? '0 : max_d;
      default:      res_o = max_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      sum_q <= '0;
    end else if (valid_i) begin
      max_q <= max_d;
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/pool2d_mc.sv
// Multi-channel 2x2/stride-2 pooling engine: sequences tap reads, feeds the
// lanes and writes one packed result per window, with enable/STOP handshake.
module pool2d_mc
  import pool_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pool_en,
  input  logic [1:0]                  mode,
  input  logic [MAT_W-1:0]            matrix,
  input  logic [SIZE_address_pix-1:0] memstartp,
  input  logic [SIZE_address_pix-1:0] memstartzap,
  output logic                        STOP,
  pool2d_mc_if.master                 mem
);

  localparam int AW = SIZE_address_pix;
  localparam int MW = MAT_W - 1;

  pool_state_e state_q, state_d;

  logic [1:0]           mode_q;
  logic [AW-1:0]        n_q, zap_q, win_q, rowb_q, raddr_q, waddr_q, wcnt_q;
  logic [MW-1:0]        m_q, row_q, col_q;
  logic [1:0]           tap_q, rtap_q;
  logic                 re_q, rvalid_q, we_q, stop_q;
  logic [SIZE_1*CH-1:0] dp_q, res;

  logic [MW-1:0] m_in, m_last;
  logic [AW-1:0] tap_off, rowb_nxt;
  logic          last_issue, fin;

  always_comb begin
    m_in       = matrix[MAT_W-1:1];
    m_last     = m_q - 1'b1;
    last_issue = (tap_q == 2'd3) && (row_q == m_last) && (col_q == m_last);
    fin        = rvalid_q && (rtap_q == 2'd3);
    rowb_nxt   = rowb_q + {n_q[AW-2:0], 1'b0};
    case (tap_q)
      2'd0:    tap_off = AW'(1);
      2'd1:    tap_off = n_q;
      default: tap_off = n_q + AW'(1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (!pool_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = (m_in == '0) ? ST_DONE : ST_RUN;
        ST_RUN:   if (last_issue) state_d = ST_DRAIN;
        ST_DRAIN: if (fin) state_d = ST_DONE;
        default:  state_d = ST_DONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= '0;
      n_q      <= '0;
      m_q      <= '0;
      zap_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      tap_q    <= '0;
      win_q    <= '0;
      rowb_q   <= '0;
      re_q     <= 1'b0;
      raddr_q  <= '0;
      rvalid_q <= 1'b0;
      rtap_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wcnt_q   <= '0;
      dp_q     <= '0;
      stop_q   <= 1'b0;
    end else begin
      stop_q   <= pool_en && (state_q == ST_DONE);
      we_q     <= pool_en && fin;
      rvalid_q <= pool_en && re_q;
      rtap_q   <= tap_q;
      if (!pool_en) begin
        re_q   <= 1'b0;
        row_q  <= '0;
        col_q  <= '0;
        tap_q  <= '0;
        wcnt_q <= '0;
      end else begin
        if (fin) begin
          dp_q    <= res;
          waddr_q <= zap_q + wcnt_q;
          wcnt_q  <= wcnt_q + AW'(1);
        end
        case (state_q)
          ST_IDLE: begin
            mode_q <= mode;
            n_q    <= AW'(matrix);
            m_q    <= m_in;
            zap_q  <= memstartzap;
            win_q  <= memstartp;
            rowb_q <= memstartp;
            row_q  <= '0;
            col_q  <= '0;
            tap_q  <= '0;
            wcnt_q <= '0;
            re_q   <= (m_in != '0);
            if (m_in != '0) raddr_q <= memstartp;
          end
          ST_RUN: begin
            if (tap_q != 2'd3) begin
              tap_q   <= tap_q + 2'd1;
              raddr_q <= win_q + tap_off;
            end else if (last_issue) begin
              re_q <= 1'b0;
            end else begin
              tap_q <= '0;
              // Next output row starts 2N past the previous row base.
              if (col_q == m_last) begin
                col_q   <= '0;
                row_q   <= row_q + 1'b1;
                rowb_q  <= rowb_nxt;
                win_q   <= rowb_nxt;
                raddr_q <= rowb_nxt;
              end else begin
                col_q   <= col_q + 1'b1;
                win_q   <= win_q + AW'(2);
                raddr_q <= win_q + AW'(2);
              end
            end
          end
          default: re_q <= 1'b0;
        endcase
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_lane
    pool_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .valid_i (rvalid_q),
      .tap_i   (rtap_q),
      .mode_i  (mode_q),
      .data_i  (mem.qp[g*SIZE_1 +: SIZE_1]),
      .res_o   (res[g*SIZE_1 +: SIZE_1])
    );
  end

  assign mem.read_addressp  = raddr_q;
  assign mem.re             = re_q;
  assign mem.write_addressp = waddr_q;
  assign mem.we             = we_q;
  assign mem.dp             = dp_q;
  assign STOP               = stop_q;

endmodule

// File: tb/tb_pool2d_mc.sv
// Directed bench for pool2d_mc: hand-computed 4x4 map over all modes, odd N,
// degenerate N, abort/restart and reset mid-run.
module tb_pool2d_mc;
  import pool_pkg::*;

  logic        clk = 1'b0;
  logic        rst, pool_en, STOP;
  logic [1:0]  mode;
  logic [9:0]  matrix;
  logic [12:0] memstartp, memstartzap;

  pool2d_mc_if mif ();

  pool2d_mc dut (
    .clk         (clk),
    .rst         (rst),
    .pool_en     (pool_en),
    .mode        (mode),
    .matrix      (matrix),
    .memstartp   (memstartp),
    .memstartzap (memstartzap),
    .STOP        (STOP),
    .mem         (mif)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:8191];
  always @(posedge clk) if (mif.re) mif.qp <= mem[mif.read_addressp];

  // window, lane, tap for the 4x4 map
  int tap_v [4][4][4] = '{
    '{'{-5,-2,-9,-3}, '{1,2,3,4}, '{-1,-2,-3,-4}, '{32767,32767,32767,32767}},
    '{'{-7,-1,-4,-2}, '{-7,5,0,1}, '{10,20,30,40}, '{-32768,-32768,-32768,-32768}},
    '{'{7,3,9,1}, '{0,0,0,0}, '{100,-100,50,-50}, '{-3,-3,-3,-2}},
    '{'{3,8,1,2}, '{-100,-200,-50,-300}, '{1,1,1,2}, '{5,-6,7,-8}}
  };
  int e_max [4][4] = '{'{-2,4,-1,32767}, '{-1,5,40,-32768}, '{9,0,100,-2}, '{8,-50,2,7}};
  int e_avg [4][4] = '{'{-5,2,-3,32767}, '{-4,-1,25,-32768}, '{5,0,0,-3}, '{3,-163,1,-1}};
  int e_rel [4][4] = '{'{0,4,0,32767}, '{0,5,40,0}, '{9,0,100,0}, '{8,0,2,7}};

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          we_cyc[$];
  logic [12:0] wa[$];
  logic [63:0] wd[$];
  logic [12:0] ra[$];
  int          re_first, re_last, re_cnt, stop_cyc, done_bad;

  function automatic logic [63:0] exp_word(input int w, input logic [1:0] md);
    logic [63:0] r;
    int v;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      case (md)
        POOL_AVG:     v = e_avg[w][l];
        POOL_MAXRELU: v = e_rel[w][l];
        default:      v = e_max[w][l];
      endcase
      r[l*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  task automatic load_map(input int base);
    int t0, tv;
    int addr [4];
    for (int w = 0; w < 4; w++) begin
      t0 = base + 8*(w/2) + 2*(w%2);
      addr = '{t0, t0+1, t0+4, t0+5};
      for (int t = 0; t < 4; t++)
        for (int l = 0; l < 4; l++) begin
          tv = tap_v[w][l][t];
          mem[addr[t]][l*16 +: 16] = tv[15:0];
        end
    end
  endtask

  task automatic run_pool(input int n, input logic [1:0] md, input int abort_at, input bit scramble);
    we_cyc.delete(); wa.delete(); wd.delete(); ra.delete();
    re_first = -1; re_last = -1; re_cnt = 0; stop_cyc = -1; done_bad = 0;
    @(negedge clk);
    matrix = 10'(n); mode = md; pool_en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mif.re) begin
        if (re_first < 0) re_first = c;
        re_last = c;
        re_cnt++;
        ra.push_back(mif.read_addressp);
      end
      if (mif.we) begin
        we_cyc.push_back(c);
        wa.push_back(mif.write_addressp);
        wd.push_back(mif.dp);
      end
      if (STOP) begin
        if (stop_cyc < 0) stop_cyc = c;
        if (mif.re || mif.we) done_bad++;
      end
      if (scramble && c == 3) begin
        mode   = (md == POOL_AVG) ? POOL_MAX : POOL_AVG;
        matrix = 10'd7;
      end
      if (c == abort_at) pool_en = 1'b0;
      if (abort_at >= 0 && c >= abort_at + 4) break;
      if (stop_cyc >= 0 && c >= stop_cyc + 3) break;
    end
  endtask

  task automatic finish_run();
    @(negedge clk);
    pool_en = 1'b0;
    @(negedge clk);
    check("stop_clear", STOP, 0);
  endtask

  task automatic check_writes(input int wn, input logic [12:0] zap, input logic [1:0] md, input bit chk_data);
    check("we_count", we_cyc.size(), wn);
    for (int k = 0; k < wn && k < we_cyc.size(); k++) begin
      check($sformatf("we_cycle[%0d]", k), we_cyc[k], 4*k + 5);
      check($sformatf("waddr[%0d]", k), wa[k], 13'(zap + k));
      if (chk_data) check($sformatf("dp[%0d] mode%0d", k, md), wd[k], exp_word(k, md));
    end
    check("stop_cycle", stop_cyc, (wn == 0) ? 1 : 4*wn + 2);
    check("re_count", re_cnt, 4*wn);
    if (wn > 0) begin
      check("re_first", re_first, 0);
      check("re_last", re_last, 4*wn - 1);
    end
    check("done_quiet", done_bad, 0);
  endtask

  task automatic check_reads(input int n, input int base);
    int m, idx, t0;
    int e [4];
    m = n / 2;
    idx = 0;
    check("read_count", ra.size(), 4*m*m);
    for (int r = 0; r < m; r++)
      for (int c = 0; c < m; c++) begin
        t0 = base + 2*r*n + 2*c;
        e = '{t0, t0+1, t0+n, t0+n+1};
        for (int t = 0; t < 4; t++) begin
          if (idx < ra.size()) check($sformatf("raddr[%0d]", idx), ra[idx], 13'(e[t]));
          idx++;
        end
      end
  endtask

  initial begin
    rst = 1'b1; pool_en = 1'b0; mode = 2'b00; matrix = '0;
    memstartp = '0; memstartzap = '0;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_re", mif.re, 0);
    check("rst_we", mif.we, 0);
    check("rst_dp", mif.dp, 0);
    check("rst_raddr", mif.read_addressp, 0);
    check("rst_waddr", mif.write_addressp, 0);
    check("rst_stop", STOP, 0);
    rst = 1'b0;

    memstartp = 13'd100; memstartzap = 13'd2000;
    load_map(100);
    run_pool(4, POOL_MAX, -1, 1'b0);
    check_writes(4, 13'd2000, POOL_MAX, 1'b1);
    check_reads(4, 100);
    finish_run();

    run_pool(4, POOL_AVG, -1, 1'b0);
    check_writes(4, 13'd2000, POOL_AVG, 1'b1);
    finish_run();

    run_pool(4, POOL_MAXRELU, -1, 1'b0);
    check_writes(4, 13'd2000, POOL_MAXRELU, 1'b1);
    finish_run();

    run_pool(4, 2'b11, -1, 1'b0);
    check_writes(4, 13'd2000, 2'b11, 1'b1);
    finish_run();

    memstartp = 13'd300; memstartzap = 13'd3000;
    run_pool(5, POOL_MAX, -1, 1'b0);
    check_writes(4, 13'd3000, POOL_MAX, 1'b0);
    check_reads(5, 300);
    if (ra.size() > 8) check("odd_win10_t0", ra[8], 310);
    finish_run();

    run_pool(1, POOL_MAX, -1, 1'b0);
    check_writes(0, 13'd3000, POOL_MAX, 1'b0);
    finish_run();
    run_pool(0, POOL_MAX, -1, 1'b0);
    check_writes(0, 13'd3000, POOL_MAX, 1'b0);
    finish_run();

    memstartp = 13'd100; memstartzap = 13'd2000;
    run_pool(4, POOL_MAX, 7, 1'b0);
    check("abort_re_count", re_cnt, 8);
    check("abort_re_last", re_last, 7);
    check("abort_we_count", we_cyc.size(), 1);
    check("abort_no_stop", stop_cyc, -1);
    run_pool(4, POOL_MAX, -1, 1'b1);
    check_writes(4, 13'd2000, POOL_MAX, 1'b1);
    check_reads(4, 100);
    finish_run();

    @(negedge clk);
    matrix = 10'd4; mode = POOL_MAX; pool_en = 1'b1;
    repeat (9) @(negedge clk);
    check("pre_rst_re", mif.re, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_re", mif.re, 0);
    check("mid_rst_we", mif.we, 0);
    check("mid_rst_dp", mif.dp, 0);
    check("mid_rst_raddr", mif.read_addressp, 0);
    check("mid_rst_waddr", mif.write_addressp, 0);
    check("mid_rst_stop", STOP, 0);
    rst = 1'b0; pool_en = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pool2d_mc.md
# pool2d_mc

Multi-channel 2×2/stride-2 pooling engine for the neuroset layer pipeline, successor to the single-channel max-pooling block. It reads a square feature map from pixel memory, reduces each non-overlapping 2×2 window per channel lane (max, average or max+ReLU), and writes one packed result word per window to a contiguous output region. It sits between a convolution layer's output buffer and the next layer, and is started and stopped by the layer sequencer through an enable/STOP handshake.

## Interface
- SIZE_1, 16: element width per channel lane (signed)
- CH, 4: channel lanes packed per memory word
- SIZE_address_pix, 13: pixel-memory address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pool_en  in  1  level enable; high = run, low = abort/idle
- mode  in  2  00 max, 01 average, 10 max then ReLU, 11 treated as 00
- matrix  in  10  input side length N (rows = columns = N)
- memstartp  in  SIZE_address_pix  input map base address
- memstartzap  in  SIZE_address_pix  output map base address
- qp  in  SIZE_1*CH  read data, valid one cycle after re
- read_addressp  out  SIZE_address_pix  read address
- re  out  1  read strobe
- write_addressp  out  SIZE_address_pix  write address
- we  out  1  write strobe, one cycle per result
- dp  out  SIZE_1*CH  result word; lane c = bits [c*SIZE_1 +: SIZE_1]
- STOP  out  1  done; held high until pool_en falls

## Operation
- Output side M = N>>1; windows W = M*M, scanned row-major. Odd N: last input row and column ignored.
- Window (r,c) taps, read order: t0 = base+2c, t1 = t0+1, t2 = t0+N, t3 = t0+N+1, with base = memstartp + 2r*N. Row base advanced by adding 2N per output row; no multiplier.
- Result k written to memstartzap + k, k = 0..W-1.
- Per lane, independent: max = signed maximum of 4 taps; average = (sum in SIZE_1+2 bits) >>> 2 (arithmetic, floor); max+ReLU = max, negative clamped to 0.
- mode and matrix sampled when pool_en rises; changes during a run ignored.
- States: IDLE, RUN, DRAIN, DONE. IDLE→RUN on pool_en rising; RUN issues reads continuously; after last t3 issued → DRAIN; after last write → DONE (STOP=1); any state → IDLE when pool_en low.
- N < 2 (W = 0): IDLE→DONE directly, no re, no we.
- Address arithmetic wraps modulo 2^SIZE_address_pix; no range check.

## Timing
- Reset values: read_addressp=0, write_addressp=0, re=0, we=0, dp=0, STOP=0; internal counters 0, state IDLE.
- Cycle 0 = first cycle with pool_en high after IDLE. Window k taps addressed in cycles 4k..4k+3, re=1 continuously from cycle 0 to 4W-1, then 0.
- Tap data arrives cycles 4k+1..4k+4; result registered, we=1 with dp and write_addressp in cycle 4k+5 only. Write of window k overlaps reads of window k+1.
- Last we in cycle 4W+1; STOP=1 from cycle 4W+2, held while pool_en high; re=we=0 in DONE.
- pool_en low mid-run: next cycle re=0, we=0, STOP=0, counters cleared; partial result discarded; dp holds last value. Re-raise restarts at window 0.
- rst dominates pool_en in the same cycle.
- Throughput 4 cycles/result; total latency 4W+2 cycles to STOP.

## Structure
- Package pool_pkg: mode encodings (POOL_MAX, POOL_AVG, POOL_MAXRELU), state enum, tap count constant 4.
- Sub-module pool_lane (one lane: running max / running sum, tap index input, final select and ReLU), instantiated CH times by generate; top holds FSM, address counters and output registers.

## Test plan
- N=4, CH=4, mode max, lane values distinct incl. negatives (e.g. taps -5,-2,-9,-3 → -2) → 4 writes at memstartzap..+3, we in cycles 5,9,13,17, STOP at cycle 18.
- Same map, mode avg: taps 1,2,3,4 → 2; taps -1,-2,-3,-4 → -3 (floor); taps 32767×4 → 32767 (no overflow, SIZE_1=16).
- Mode max+ReLU: taps -7,-1,-4,-2 → 0; taps -7,5,0,1 → 5.
- N=5 odd: 4 writes only; addresses show row stride 5, window (1,0) t0 = memstartp+10; column/row 4 never read.
- N=1 and N=0: STOP at cycle 1 after rise, re and we never asserted.
- Abort: drop pool_en at cycle 7 of N=4 run → re/we 0 next cycle, STOP stays 0; re-raise → full run from window 0, identical outputs; rst asserted mid-run → all outputs at reset values next cycle.
